// File: rtl/pico_reply_mailbox.sv
// pico_reply_mailbox: byte FIFO carrying data from Pico2 back to Pico1.
// Pico2 pushes with OUTPUT to P2_DIN_PORT. Pico1 pops with INPUT from
// P1_DOUT_PORT and polls status, or takes the interrupt.
//
// Strobe semantics: an access happens in exactly the cycle where the core's
// strobe is high and its port_id matches. Read data is combinational from
// port_id and registered state, so the core samples it in that same cycle.
// State changes from a strobe (pointer moves, flags, irq) appear on the next
// rising clk. There is no back-pressure: a push into a full FIFO is dropped
// and sets OVF, and a pop from an empty FIFO returns 8'h00 and sets UNF.
module pico_reply_mailbox #(
  parameter int         DEPTH        = 4,
  parameter logic [7:0] P2_DIN_PORT  = 8'd40,
  parameter logic [7:0] P2_STAT_PORT = 8'd42,
  parameter logic [7:0] P1_DOUT_PORT = 8'd41,
  parameter logic [7:0] P1_STAT_PORT = 8'd42,
  parameter logic [7:0] P1_CTRL_PORT = 8'd43
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] p1_port_id,
  input  logic [7:0] p1_out_port,
  input  logic       p1_write_strobe,
  input  logic       p1_read_strobe,
  output logic [7:0] p1_in_data,
  output logic       p1_interrupt,
  input  logic       p1_interrupt_ack,
  input  logic [7:0] p2_port_id,
  input  logic [7:0] p2_out_port,
  input  logic       p2_write_strobe,
  input  logic       p2_read_strobe,
  output logic [7:0] p2_in_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          unf;
  logic          irq_pending;

  logic full;
  logic empty;
  logic push_req;
  logic pop_req;
  logic ctrl_wr;
  logic flush;
  logic clr_flags;
  logic pop_ok;
  logic push_ok;
  logic ovf_set;
  logic unf_set;
  logic irq_set;
  logic [7:0] status;
  logic [3:0] count4;

  // Pico2 reads do not change state and the upper control bits are reserved.
  logic unused_ok;
  assign unused_ok = ^{p2_read_strobe, p1_out_port[7:2]};

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_req  = p2_write_strobe && (p2_port_id == P2_DIN_PORT);
  assign pop_req   = p1_read_strobe  && (p1_port_id == P1_DOUT_PORT);
  assign ctrl_wr   = p1_write_strobe && (p1_port_id == P1_CTRL_PORT);
  assign flush     = ctrl_wr && p1_out_port[1];
  assign clr_flags = ctrl_wr && p1_out_port[0];

  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign pop_ok  = pop_req && !empty;
  assign push_ok = push_req && !flush && (!full || pop_ok);
  assign ovf_set = push_req && !flush && full && !pop_ok;
  assign unf_set = pop_req && empty;
  // count goes 0 -> 1 exactly when a push is accepted into an empty FIFO.
  assign irq_set = push_ok && empty;

  assign count4 = 4'(count);
  assign status = {count4, unf, ovf, empty, full};

  // Storage array; contents need no reset because empty hides them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= p2_out_port;
  end

  // Pointers, count, sticky flags and interrupt request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        count <= count + CW'(push_ok) - CW'(pop_ok);
      end
      // A set in the same cycle as a clear wins.
      if (ovf_set)        ovf <= 1'b1;
      else if (clr_flags) ovf <= 1'b0;
      if (unf_set)        unf <= 1'b1;
      else if (clr_flags) unf <= 1'b0;
      // Ack and flush both beat a simultaneous set.
      if (p1_interrupt_ack || flush) irq_pending <= 1'b0;
      else if (irq_set)              irq_pending <= 1'b1;
    end
  end

  assign p1_interrupt = irq_pending;

  // Pico1 read mux: data port peeks/pops the head, status port shows flags.
  always_comb begin
    p1_in_data = 8'h00;
    if (p1_port_id == P1_DOUT_PORT) begin
      if (!empty) p1_in_data = mem[rd_ptr];
    end else if (p1_port_id == P1_STAT_PORT) begin
      p1_in_data = status;
    end
  end

  // Pico2 read mux: only the status port is readable.
  always_comb begin
    p2_in_data = 8'h00;
    if (p2_port_id == P2_STAT_PORT) p2_in_data = status;
  end

endmodule

// File: tb/tb_pico_reply_mailbox.sv
// tb_pico_reply_mailbox: directed scenarios plus random traffic, checked
// against a byte-queue reference model through expected-value queues.
module tb_pico_reply_mailbox;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] p1_port_id = 8'h00;
  logic [7:0] p1_out_port = 8'h00;
  logic       p1_write_strobe = 1'b0;
  logic       p1_read_strobe = 1'b0;
  logic [7:0] p1_in_data;
  logic       p1_interrupt;
  logic       p1_interrupt_ack = 1'b0;
  logic [7:0] p2_port_id = 8'h00;
  logic [7:0] p2_out_port = 8'h00;
  logic       p2_write_strobe = 1'b0;
  logic       p2_read_strobe = 1'b0;
  logic [7:0] p2_in_data;

  pico_reply_mailbox #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .p1_port_id       (p1_port_id),
    .p1_out_port      (p1_out_port),
    .p1_write_strobe  (p1_write_strobe),
    .p1_read_strobe   (p1_read_strobe),
    .p1_in_data       (p1_in_data),
    .p1_interrupt     (p1_interrupt),
    .p1_interrupt_ack (p1_interrupt_ack),
    .p2_port_id       (p2_port_id),
    .p2_out_port      (p2_out_port),
    .p2_write_strobe  (p2_write_strobe),
    .p2_read_strobe   (p2_read_strobe),
    .p2_in_data       (p2_in_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard queues ----------------
  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];       // Pico1 data-port reads (pop or peek)
  logic [7:0] exp_stat_q[$];  // Pico1 status reads
  logic [7:0] exp_stat2_q[$]; // Pico2 status reads
  logic [7:0] exp_irq_q[$];   // one entry per driven cycle

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_irq = 1'b0;

  function automatic logic [7:0] model_status();
    logic [3:0] c;
    c = 4'(mq.size());
    return {c, m_unf, m_ovf, mq.size() == 0, mq.size() == DEPTH};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_irq = 1'b0;
  endtask

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h", nm, got, exp);
    end
  endtask

  task automatic missing(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=no_expectation exp=queued_value", nm);
  endtask

  // ---------------- driver ----------------
  // p1op: 0 idle, 1 pop, 2 status read, 3 ctrl write, 4 peek data port
  // p2op: 0 idle, 1 push, 2 status read
  task automatic cyc(input int p1op, input logic [7:0] p1val,
                     input int p2op, input logic [7:0] p2val, input logic ack);
    logic flush, clr, was_empty, ovf_set, unf_set, irq_set;
    @(posedge clk); #1;
    p1_read_strobe   = (p1op == 1) || (p1op == 2);
    p1_write_strobe  = (p1op == 3);
    case (p1op)
      1, 4:    p1_port_id = 8'd41;
      2:       p1_port_id = 8'd42;
      3:       p1_port_id = 8'd43;
      default: p1_port_id = 8'h00;
    endcase
    p1_out_port      = p1val;
    p1_interrupt_ack = ack;
    p2_write_strobe  = (p2op == 1);
    p2_read_strobe   = (p2op == 2);
    case (p2op)
      1:       p2_port_id = 8'd40;
      2:       p2_port_id = 8'd42;
      default: p2_port_id = 8'h00;
    endcase
    p2_out_port = p2val;

    // expected outputs during this cycle come from the pre-edge model
    exp_irq_q.push_back({7'd0, m_irq});
    if (p1op == 1 || p1op == 4) exp_q.push_back(mq.size() > 0 ? mq[0] : 8'h00);
    if (p1op == 2) exp_stat_q.push_back(model_status());
    if (p2op == 2) exp_stat2_q.push_back(model_status());

    // model update for the coming edge
    flush     = (p1op == 3) && p1val[1];
    clr       = (p1op == 3) && p1val[0];
    was_empty = (mq.size() == 0);
    ovf_set = 1'b0;
    unf_set = 1'b0;
    irq_set = 1'b0;
    if (p1op == 1) begin
      if (!was_empty) void'(mq.pop_front());
      else unf_set = 1'b1;
    end
    if (p2op == 1 && !flush) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(p2val);
        if (was_empty) irq_set = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
    if (flush) mq.delete();
    m_ovf = ovf_set | (m_ovf & ~clr);
    m_unf = unf_set | (m_unf & ~clr);
    if (ack || flush) m_irq = 1'b0;
    else if (irq_set) m_irq = 1'b1;
  endtask

  task automatic push(input logic [7:0] v);
    cyc(0, 8'h00, 1, v, 1'b0);
  endtask

  task automatic pop_is(input logic [7:0] v, input string nm);
    cyc(1, 8'h00, 0, 8'h00, 1'b0);
    @(negedge clk);
    check(nm, p1_in_data, v);
  endtask

  task automatic stat_is(input logic [7:0] v, input string nm);
    cyc(2, 8'h00, 2, 8'h00, 1'b0);
    @(negedge clk);
    check({nm, "_p1"}, p1_in_data, v);
    check({nm, "_p2"}, p2_in_data, v);
  endtask

  task automatic irq_is(input logic v, input string nm);
    cyc(0, 8'h00, 0, 8'h00, 1'b0);
    @(negedge clk);
    check(nm, {7'd0, p1_interrupt}, {7'd0, v});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    p1_read_strobe = 1'b0;
    p1_write_strobe = 1'b0;
    p1_interrupt_ack = 1'b0;
    p2_write_strobe = 1'b0;
    p2_read_strobe = 1'b0;
    p1_port_id = 8'h00;
    p2_port_id = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_irq_q.size() > 0) begin
      check("irq", {7'd0, p1_interrupt}, exp_irq_q.pop_front());
      if (p1_port_id == 8'd41) begin
        if (exp_q.size() > 0) check("p1_data", p1_in_data, exp_q.pop_front());
        else missing("p1_data");
      end else if (p1_port_id == 8'd42) begin
        if (exp_stat_q.size() > 0) check("p1_stat", p1_in_data, exp_stat_q.pop_front());
        else missing("p1_stat");
      end else begin
        check("p1_nomatch", p1_in_data, 8'h00);
      end
      if (p2_port_id == 8'd42) begin
        if (exp_stat2_q.size() > 0) check("p2_stat", p2_in_data, exp_stat2_q.pop_front());
        else missing("p2_stat");
      end else begin
        check("p2_nomatch", p2_in_data, 8'h00);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int p1op, p2op, r;
    logic [7:0] cv;

    do_reset();
    stat_is(8'h02, "reset_stat");
    irq_is(1'b0, "reset_irq");

    // order and wrap
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    stat_is(8'h41, "full_stat");
    pop_is(8'hA1, "pop_a1"); pop_is(8'hA2, "pop_a2");
    pop_is(8'hA3, "pop_a3"); pop_is(8'hA4, "pop_a4");
    stat_is(8'h02, "drained_stat");
    for (int i = 0; i < 6; i += 3) begin
      for (int j = 0; j < 3; j++) push(8'hB0 + 8'(i + j));
      for (int j = 0; j < 3; j++) pop_is(8'hB0 + 8'(i + j), "wrap_pop");
    end

    // overflow / underflow
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5);
    stat_is(8'h45, "ovf_stat");
    pop_is(8'hC1, "ovf_pop1"); pop_is(8'hC2, "ovf_pop2");
    pop_is(8'hC3, "ovf_pop3"); pop_is(8'hC4, "ovf_pop4");
    pop_is(8'h00, "unf_pop");
    stat_is(8'h0E, "unf_stat");
    cyc(3, 8'h01, 0, 8'h00, 1'b0);
    stat_is(8'h02, "clr_stat");

    // simultaneous push and pop
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    cyc(1, 8'h00, 1, 8'hD5, 1'b0);
    @(negedge clk);
    check("sim_full_pop", p1_in_data, 8'hD1);
    stat_is(8'h41, "sim_full_stat");
    pop_is(8'hD2, "sim_d2"); pop_is(8'hD3, "sim_d3");
    pop_is(8'hD4, "sim_d4"); pop_is(8'hD5, "sim_d5");
    cyc(1, 8'h00, 1, 8'hE1, 1'b0);
    @(negedge clk);
    check("sim_empty_pop", p1_in_data, 8'h00);
    stat_is(8'h18, "sim_empty_stat");
    cyc(3, 8'h01, 0, 8'h00, 1'b0);
    pop_is(8'hE1, "sim_e1");

    // interrupt
    cyc(0, 8'h00, 0, 8'h00, 1'b1);
    irq_is(1'b0, "irq_acked");
    push(8'hF1);
    irq_is(1'b1, "irq_rise");
    push(8'hF2);
    irq_is(1'b1, "irq_hold");
    cyc(0, 8'h00, 0, 8'h00, 1'b1);
    irq_is(1'b0, "irq_fall");
    pop_is(8'hF1, "irq_pop1"); pop_is(8'hF2, "irq_pop2");
    push(8'hF3);
    irq_is(1'b1, "irq_again");

    // flush
    push(8'h11); push(8'h12);
    cyc(3, 8'h02, 0, 8'h00, 1'b0);
    stat_is(8'h02, "flush_stat");
    irq_is(1'b0, "flush_irq");

    // asynchronous reset in the middle of a cycle
    push(8'h21); push(8'h22);
    @(negedge clk);
    #2;
    p1_read_strobe = 1'b0;
    p2_write_strobe = 1'b0;
    p1_port_id = 8'd42;
    p2_port_id = 8'd42;
    reset_n = 1'b0;
    #1;
    check("arst_p1_stat", p1_in_data, 8'h02);
    check("arst_p2_stat", p2_in_data, 8'h02);
    check("arst_irq", {7'd0, p1_interrupt}, 8'h00);
    p1_port_id = 8'd41;
    #1;
    check("arst_p1_data", p1_in_data, 8'h00);
    do_reset();
    stat_is(8'h02, "post_arst_stat");

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        3, 4, 5: p1op = 1;
        6:       p1op = 2;
        7:       p1op = 4;
        8:       p1op = 3;
        default: p1op = 0;
      endcase
      r = $urandom_range(0, 9);
      if (r < 5) p2op = 1;
      else if (r == 5) p2op = 2;
      else p2op = 0;
      cv = {6'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
      b = 8'($urandom_range(0, 255));
      cyc(p1op, cv, p2op, b, ($urandom_range(0, 7) == 0));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() + exp_stat_q.size() + exp_stat2_q.size() + exp_irq_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d exp=0", exp_q.size() + exp_stat_q.size() + exp_stat2_q.size() + exp_irq_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
